// File: rtl/frame_merge_arbiter.sv
// Merges CHANNEL_NUM framed streams onto one output, one whole frame at a time.
// Round-robin grant, single-register output stage, header check and frame-length watchdog.
module frame_merge_arbiter #(
  parameter int unsigned CHANNEL_NUM      = 4,
  parameter int unsigned TDATA_WIDTH      = 64,
  parameter int unsigned MAX_FRAME_LENGTH = 200
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [CHANNEL_NUM*TDATA_WIDTH-1:0] S_TDATA,
  input  logic [CHANNEL_NUM-1:0]             S_TVALID,
  input  logic [CHANNEL_NUM-1:0]             S_TLAST,
  output logic [CHANNEL_NUM-1:0]             S_TREADY,
  output logic [TDATA_WIDTH-1:0]             M_TDATA,
  output logic                               M_TVALID,
  output logic                               M_TLAST,
  input  logic                               M_TREADY,
  output logic [$clog2(CHANNEL_NUM)-1:0]     GRANT_CH,
  output logic                               HDR_ERR,
  output logic                               TRUNC_ERR
);

  // Bits needed to hold CHANNEL_NUM-1, and MAX_FRAME_LENGTH+2 plus one spare bit.
  localparam int unsigned GrantW = $clog2(CHANNEL_NUM);
  localparam int unsigned CntW   = $clog2(MAX_FRAME_LENGTH + 3) + 1;

  localparam logic [CntW-1:0]   TruncCnt = CntW'(MAX_FRAME_LENGTH + 2);
  localparam logic [GrantW-1:0] LastCh   = GrantW'(CHANNEL_NUM - 1);

  typedef enum logic {StIdle, StXfer} state_e;

  state_e            state_q;
  logic [GrantW-1:0] rr_ptr_q;
  logic [CntW-1:0]   beat_cnt_q;

  logic [GrantW-1:0]      pick;
  logic                   pick_vld;
  logic [TDATA_WIDTH-1:0] s_data;
  logic                   s_valid_g;
  logic                   s_last_g;
  logic                   s_ready;
  logic                   accept;
  logic [CntW-1:0]        beat_cnt_inc;
  logic                   trunc_hit;
  logic                   beat_last;
  logic                   hdr_bad;

  // First requesting channel at or after ptr, wrapping.
  function automatic logic [GrantW-1:0] rr_pick(input logic [GrantW-1:0]    ptr,
                                                input logic [CHANNEL_NUM-1:0] req);
    logic [GrantW-1:0] sel;
    logic              found;
    int unsigned       idx;
    sel   = ptr;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      idx = (32'(ptr) + i) % CHANNEL_NUM;
      if (!found && req[GrantW'(idx)]) begin
        sel   = GrantW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick     = rr_pick(rr_ptr_q, S_TVALID);
    pick_vld = |S_TVALID;

    s_data    = S_TDATA[32'(GRANT_CH) * TDATA_WIDTH +: TDATA_WIDTH];
    s_valid_g = S_TVALID[GRANT_CH];
    s_last_g  = S_TLAST[GRANT_CH];

    // Accept whenever the output register is empty or draining this cycle.
    s_ready  = (state_q == StXfer) && (!M_TVALID || M_TREADY);
    S_TREADY = s_ready ? (CHANNEL_NUM'(1) << GRANT_CH) : '0;
    accept   = s_ready && s_valid_g;

    beat_cnt_inc = beat_cnt_q + 1'b1;
    trunc_hit    = (beat_cnt_inc == TruncCnt);
    beat_last    = s_last_g || trunc_hit;
    hdr_bad      = (beat_cnt_q == '0) && (s_data[TDATA_WIDTH-1 -: 8] != 8'hFF);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      GRANT_CH   <= '0;
      beat_cnt_q <= '0;
      M_TDATA    <= '1;
      M_TVALID   <= 1'b0;
      M_TLAST    <= 1'b0;
      HDR_ERR    <= 1'b0;
      TRUNC_ERR  <= 1'b0;
    end else begin
      HDR_ERR   <= 1'b0;
      TRUNC_ERR <= 1'b0;
      if (M_TVALID && M_TREADY) begin
        M_TVALID <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            GRANT_CH   <= pick;
            beat_cnt_q <= '0;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          if (accept) begin
            M_TDATA    <= s_data;
            M_TVALID   <= 1'b1;
            M_TLAST    <= beat_last;
            HDR_ERR    <= hdr_bad;
            TRUNC_ERR  <= trunc_hit && !s_last_g;
            beat_cnt_q <= beat_cnt_inc;
            if (beat_last) begin
              rr_ptr_q <= (GRANT_CH == LastCh) ? '0 : GRANT_CH + 1'b1;
              state_q  <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/frame_merge_arbiter.md
FRAME_MERGE_ARBITER -- requirements
Module: frame_merge_arbiter

Interface
REQ-001 SHALL have parameter CHANNEL_NUM, default 4, meaning the number of DataFrameGenerator output streams merged (2..8).
REQ-002 SHALL have parameter TDATA_WIDTH, default 64, meaning the beat width (header, data and footer words).
REQ-003 SHALL have parameter MAX_FRAME_LENGTH, default 200, meaning the maximum number of data beats between header and footer.
REQ-004 SHALL have port CLK, input, 1, the single clock for all logic.
REQ-005 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port S_TDATA, input, CHANNEL_NUM*TDATA_WIDTH; channel k occupies bits [k*TDATA_WIDTH +: TDATA_WIDTH].
REQ-007 SHALL have port S_TVALID, input, CHANNEL_NUM, per-channel beat valid.
REQ-008 SHALL have port S_TLAST, input, CHANNEL_NUM, per-channel footer-beat marker.
REQ-009 SHALL have port S_TREADY, output, CHANNEL_NUM, per-channel accept.
REQ-010 SHALL have port M_TDATA, output, TDATA_WIDTH, the merged beat.
REQ-011 SHALL have port M_TVALID, output, 1, merged beat valid.
REQ-012 SHALL have port M_TLAST, output, 1, merged frame end.
REQ-013 SHALL have port M_TREADY, input, 1, downstream accept.
REQ-014 SHALL have port GRANT_CH, output, clogb2(CHANNEL_NUM-1), the currently or last granted channel.
REQ-015 SHALL have port HDR_ERR, output, 1, a one-cycle pulse on a bad header.
REQ-016 SHALL have port TRUNC_ERR, output, 1, a one-cycle pulse on a watchdog truncation.

Function
REQ-017 A beat SHALL transfer on a slave port when S_TVALID[k] & S_TREADY[k] at a CLK edge, and on the master port when M_TVALID & M_TREADY.
REQ-018 The FSM SHALL have two states, IDLE and XFER.
REQ-019 IDLE SHALL hold all S_TREADY at 0.
REQ-020 In IDLE, if any S_TVALID is 1, the block SHALL choose the first asserted channel searching round-robin from rr_ptr upward with wrap, register it into GRANT_CH, and enter XFER on the next edge.
REQ-021 Arbitration SHALL cost exactly 1 cycle.
REQ-022 In XFER, S_TREADY[GRANT_CH] SHALL equal (~M_TVALID | M_TREADY), and all other S_TREADY SHALL be 0.
REQ-023 The output stage SHALL be a single register: an accepted beat appears on M_TDATA/M_TLAST with M_TVALID=1 on the following cycle (latency 1).
REQ-024 M_TVALID and M_TDATA SHALL hold stable while M_TREADY=0.
REQ-025 Back-to-back beats SHALL sustain 1 beat/cycle when M_TREADY=1.
REQ-026 A 9-bit-minimum beat counter (width clogb2(MAX_FRAME_LENGTH+2)+1) SHALL clear on grant and increment on each accepted slave beat.
REQ-027 On the first accepted beat of a frame, if bits [TDATA_WIDTH-1 -: 8] != 8'hFF, HDR_ERR SHALL pulse for 1 cycle, coincident with that beat on M_TDATA; the beat SHALL still be forwarded.
REQ-028 When an accepted beat has S_TLAST=1: M_TLAST=1 on that beat, rr_ptr SHALL be set to GRANT_CH+1 (wrapping to 0 after CHANNEL_NUM-1), and the FSM SHALL return to IDLE.
REQ-029 When the counter reaches MAX_FRAME_LENGTH+2 accepted beats with no S_TLAST: that beat SHALL be emitted with M_TLAST forced to 1, TRUNC_ERR SHALL pulse for 1 cycle, and REQ-028 pointer/IDLE handling SHALL apply. The channel's remaining beats are arbitrated as a new frame.
REQ-030 A frame SHALL never be interleaved with another channel's beats.
REQ-031 Simultaneous requests SHALL be resolved purely by rr_ptr.
REQ-032 A channel dropping S_TVALID mid-frame SHALL keep the grant; the block SHALL wait without a timeout.
REQ-033 GRANT_CH SHALL hold its value in IDLE until the next grant.

Reset
REQ-034 While RESET=1, asynchronously: state=IDLE, rr_ptr=0, GRANT_CH=0, counter=0, M_TVALID=0, M_TLAST=0, M_TDATA=all ones, S_TREADY=0, HDR_ERR=0, TRUNC_ERR=0.
REQ-035 Reset asserted mid-frame SHALL discard the in-flight beat and frame; after release, arbitration SHALL restart from channel 0 with no partial-frame recovery.
REQ-036 The first grant SHALL be possible on the first CLK edge after RESET falls.

Verification
REQ-037 Single frame on ch2 (header FF..., 3 data beats, TLAST footer), M_TREADY=1 -> GRANT_CH=2, 5 beats out in order, M_TLAST on beat 5, no errors, rr_ptr=3.
REQ-038 Ch0 and ch3 both valid from reset -> ch0 frame completes fully, then ch3 after 1 IDLE cycle; the next simultaneous ch0/ch3 request -> ch0 again only after ch3 (ptr wrap to 0).
REQ-039 M_TREADY toggling 1,0,0,1 during a frame -> M_TDATA stable during stalls, no beat lost or duplicated, S_TREADY low while the output is full and not ready.
REQ-040 Frame with first word 0x7F00_0000_0000_0000 -> HDR_ERR=1 for exactly the cycle that beat is valid on M_TDATA, frame forwarded intact.
REQ-041 MAX_FRAME_LENGTH=4, channel sends 8 beats without TLAST -> beat 6 out with M_TLAST=1, TRUNC_ERR pulse, beats 7-8 re-arbitrated as a new frame (HDR_ERR expected).
REQ-042 RESET pulsed on beat 3 of a 5-beat frame -> all outputs at reset values immediately, then a clean grant to channel 0 if it is valid.
